// File: rtl/evm_ballot_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// evm_pkg
// Shared definitions for the ballot controller slice: FSM state encoding,
// party count and one-hot party codes, ballot counter width, and a one-hot
// selection check used by the controller.
// -----------------------------------------------------------------------------
package evm_pkg;

    localparam int NUM_PARTIES  = 4;
    localparam int BALLOT_CNT_W = 7;

    localparam logic [NUM_PARTIES-1:0] PARTY1 = 4'b0001;
    localparam logic [NUM_PARTIES-1:0] PARTY2 = 4'b0010;
    localparam logic [NUM_PARTIES-1:0] PARTY3 = 4'b0100;
    localparam logic [NUM_PARTIES-1:0] PARTY4 = 4'b1000;

    localparam logic [BALLOT_CNT_W-1:0] BALLOT_CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_e;

    // True when exactly one bit of the selection is set.
    function automatic logic is_one_hot(input logic [NUM_PARTIES-1:0] sel);
        return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/evm_ballot_ctrl_if.sv
// -----------------------------------------------------------------------------
// evm_ballot_ctrl_if
// Groups the ballot controller's front-panel inputs and its vote bus toward
// the downstream counter.
//   master : controller side (consumes raw panel inputs, drives vote bus)
//   slave  : environment side (drives raw panel inputs, consumes vote bus)
// Signals:
//   voting_en, raw_ballot_issue, raw_button, raw_switch[3:0]  panel inputs
//   vote_strobe, vote_party[3:0], ballot_ready, invalid_sel,
//   beep, ballots_cast[6:0], ballot_timeout                    controller outputs
// -----------------------------------------------------------------------------
interface evm_ballot_ctrl_if;
    import evm_pkg::*;

    logic                    voting_en;
    logic                    raw_ballot_issue;
    logic                    raw_button;
    logic [NUM_PARTIES-1:0]  raw_switch;

    logic                    vote_strobe;
    logic [NUM_PARTIES-1:0]  vote_party;
    logic                    ballot_ready;
    logic                    invalid_sel;
    logic                    beep;
    logic [BALLOT_CNT_W-1:0] ballots_cast;
    logic                    ballot_timeout;

    modport master (
        input  voting_en, raw_ballot_issue, raw_button, raw_switch,
        output vote_strobe, vote_party, ballot_ready, invalid_sel,
               beep, ballots_cast, ballot_timeout
    );

    modport slave (
        output voting_en, raw_ballot_issue, raw_button, raw_switch,
        input  vote_strobe, vote_party, ballot_ready, invalid_sel,
               beep, ballots_cast, ballot_timeout
    );

endinterface

// File: rtl/evm_ballot_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// evm_debounce
// Two-flop synchroniser followed by a stability counter. The debounced level
// flips only after DEBOUNCE_CYCLES consecutive synchronised samples that all
// differ from the current level; any sample equal to the level restarts the
// count. A registered one-cycle rise pulse follows each 0->1 level change.
// Ports:
//   clk, reset  system clock, asynchronous active-high reset
//   raw_i       asynchronous bouncy input
//   rise_o      one-cycle pulse, one cycle after the debounced level rises
// -----------------------------------------------------------------------------
module evm_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic rise_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_prev_q;
    logic             rise_q;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = ~level_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            rise_q       <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], raw_i};
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            rise_q       <= level_q & ~level_prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/evm_ballot_ctrl.sv
// -----------------------------------------------------------------------------
// evm_ballot_ctrl
// Front-end for the vote-counting stage. Debounces the officer's ballot-issue
// button and the voter's cast button, synchronises the party switches, and
// allows exactly one vote per issued ballot. Each accepted vote produces a
// one-cycle vote_strobe with a one-hot vote_party, bumps a saturating
// ballots_cast counter and starts a LOCKOUT dead time during which beep is high.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high; returns to IDLE, any armed ballot is lost
//   bus    evm_ballot_ctrl_if.master (panel inputs in, vote bus out)
// Build option:
//   BALLOT_TIMEOUT_EN  when defined, an armed ballot expires after
//                      TIMEOUT_CYCLES without an accepted vote and
//                      ballot_timeout pulses; otherwise ballot_timeout is 0.
// -----------------------------------------------------------------------------
module evm_ballot_ctrl
    import evm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LOCKOUT_CYCLES  = 32,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    evm_ballot_ctrl_if.master bus
);

    localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);

`ifdef BALLOT_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`endif

    logic btn_rise;
    logic issue_rise;

    evm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (bus.raw_button),
        .rise_o (btn_rise)
    );

    evm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_issue_db (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (bus.raw_ballot_issue),
        .rise_o (issue_rise)
    );

    // Switches are only synchronised; the cast-button debounce already
    // gives the voter's selection time to settle before it is sampled.
    logic [NUM_PARTIES-1:0] sw_meta_q, sw_sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= bus.raw_switch;
            sw_sync_q <= sw_meta_q;
        end
    end

    state_e                  state_q;
    logic [LOCK_W-1:0]       lock_cnt_q;
    logic                    vote_strobe_q;
    logic [NUM_PARTIES-1:0]  vote_party_q;
    logic                    ballot_ready_q;
    logic                    invalid_sel_q;
    logic                    beep_q;
    logic [BALLOT_CNT_W-1:0] ballots_cast_q;
`ifdef BALLOT_TIMEOUT_EN
    logic [TMO_W-1:0]        tmo_cnt_q;
    logic                    ballot_timeout_q;
`endif

    logic sel_valid;
    assign sel_valid = is_one_hot(sw_sync_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            lock_cnt_q       <= '0;
            vote_strobe_q    <= 1'b0;
            vote_party_q     <= '0;
            ballot_ready_q   <= 1'b0;
            invalid_sel_q    <= 1'b0;
            beep_q           <= 1'b0;
            ballots_cast_q   <= '0;
`ifdef BALLOT_TIMEOUT_EN
            tmo_cnt_q        <= '0;
            ballot_timeout_q <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low and are raised only on the event cycle.
            vote_strobe_q    <= 1'b0;
            invalid_sel_q    <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
            ballot_timeout_q <= 1'b0;
`endif
            unique case (state_q)
                ST_IDLE: begin
                    if (issue_rise && bus.voting_en) begin
                        state_q        <= ST_ARMED;
                        ballot_ready_q <= 1'b1;
`ifdef BALLOT_TIMEOUT_EN
                        tmo_cnt_q      <= '0;
`endif
                    end
                end

                ST_ARMED: begin
                    // Closing the election outranks a same-cycle press.
                    if (!bus.voting_en) begin
                        state_q        <= ST_IDLE;
                        ballot_ready_q <= 1'b0;
                    end else if (btn_rise && sel_valid) begin
                        state_q        <= ST_LOCKOUT;
                        ballot_ready_q <= 1'b0;
                        beep_q         <= 1'b1;
                        lock_cnt_q     <= LOCK_LOAD;
                        vote_strobe_q  <= 1'b1;
                        vote_party_q   <= sw_sync_q;
                        if (ballots_cast_q != BALLOT_CNT_MAX) begin
                            ballots_cast_q <= ballots_cast_q + 1'b1;
                        end
                    end else begin
                        if (btn_rise) begin
                            invalid_sel_q <= 1'b1;
                        end
`ifdef BALLOT_TIMEOUT_EN
                        // An invalid press does not restart the expiry count.
                        if (tmo_cnt_q == TMO_LAST) begin
                            state_q          <= ST_IDLE;
                            ballot_ready_q   <= 1'b0;
                            ballot_timeout_q <= 1'b1;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        end
`endif
                    end
                end

                ST_LOCKOUT: begin
                    // Button and voting_en are ignored until the dead time ends.
                    if (lock_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        beep_q  <= 1'b0;
                    end else begin
                        lock_cnt_q <= lock_cnt_q - 1'b1;
                    end
                end

                default: begin
                    state_q        <= ST_IDLE;
                    ballot_ready_q <= 1'b0;
                    beep_q         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vote_strobe    = vote_strobe_q;
    assign bus.vote_party     = vote_party_q;
    assign bus.ballot_ready   = ballot_ready_q;
    assign bus.invalid_sel    = invalid_sel_q;
    assign bus.beep           = beep_q;
    assign bus.ballots_cast   = ballots_cast_q;
`ifdef BALLOT_TIMEOUT_EN
    assign bus.ballot_timeout = ballot_timeout_q;
`else
    assign bus.ballot_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_evm_ballot_ctrl
// Directed scenarios plus a randomized phase for evm_ballot_ctrl, compared on
// every cycle against a behavioural model built from sample histories.
// -----------------------------------------------------------------------------
module tb_evm_ballot_ctrl;
    import evm_pkg::*;

    localparam int DEB  = 4;
    localparam int LOCK = 8;
    localparam int TMO  = 20;

    logic clk = 1'b0;
    logic reset;

    evm_ballot_ctrl_if bus();

    evm_ballot_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .LOCKOUT_CYCLES  (LOCK),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Histories hold raw samples taken at each edge,
    // index 0 newest. The debounced level flips when the DEB samples seen
    // by the debouncer (two edges old and older) all differ from it.
    // ------------------------------------------------------------------
    logic [DEB:0] m_btn_h, m_iss_h;
    logic [3:0]   m_sw_h [2];
    logic [2:0]   m_lvl_b, m_lvl_i;   // debounced levels after recent edges, [0] newest
    int           m_mode;             // 0 idle, 1 armed, 2 lockout
    int           m_lock_left, m_tmo;

    logic       e_strobe, e_ready, e_inv, e_beep, e_tmo;
    logic [3:0] e_party;
    int         e_cnt;

    function automatic logic all_differ(input logic [DEB:0] h, input logic lvl);
        for (int i = 1; i <= DEB; i++) if (h[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_btn_h = '0; m_iss_h = '0; m_sw_h[0] = '0; m_sw_h[1] = '0;
        m_lvl_b = '0; m_lvl_i = '0;
        m_mode = 0; m_lock_left = 0; m_tmo = 0;
        e_strobe = 0; e_ready = 0; e_inv = 0; e_beep = 0; e_tmo = 0;
        e_party = '0; e_cnt = 0;
    endtask

    task automatic model_step();
        logic [3:0] sw;
        logic nb, ni, brise, irise;
        sw    = m_sw_h[1];
        nb    = m_lvl_b[0] ^ all_differ(m_btn_h, m_lvl_b[0]);
        ni    = m_lvl_i[0] ^ all_differ(m_iss_h, m_lvl_i[0]);
        brise = m_lvl_b[1] & ~m_lvl_b[2];
        irise = m_lvl_i[1] & ~m_lvl_i[2];
        m_btn_h  = {m_btn_h[DEB-1:0], bus.raw_button};
        m_iss_h  = {m_iss_h[DEB-1:0], bus.raw_ballot_issue};
        m_sw_h[1] = m_sw_h[0];
        m_sw_h[0] = bus.raw_switch;
        m_lvl_b  = {m_lvl_b[1:0], nb};
        m_lvl_i  = {m_lvl_i[1:0], ni};

        e_strobe = 0; e_inv = 0; e_tmo = 0;
        case (m_mode)
            0: if (irise && bus.voting_en) begin m_mode = 1; m_tmo = 0; end
            1: begin
                if (!bus.voting_en) m_mode = 0;
                else if (brise && $countones(sw) == 1) begin
                    e_strobe = 1; e_party = sw;
                    if (e_cnt < 127) e_cnt++;
                    m_mode = 2; m_lock_left = LOCK;
                end else begin
                    if (brise) e_inv = 1;
`ifdef BALLOT_TIMEOUT_EN
                    m_tmo++;
                    if (m_tmo == TMO) begin e_tmo = 1; m_mode = 0; end
`endif
                end
            end
            default: begin
                m_lock_left--;
                if (m_lock_left == 0) m_mode = 0;
            end
        endcase
        e_ready = (m_mode == 1);
        e_beep  = (m_mode == 2);
    endtask

    // Compare process: model advances on each edge, outputs checked 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset) model_step();
            #1;
            check("strobe", bus.vote_strobe,    e_strobe);
            check("party",  bus.vote_party,     e_party);
            check("ready",  bus.ballot_ready,   e_ready);
            check("inv",    bus.invalid_sel,    e_inv);
            check("beep",   bus.beep,           e_beep);
            check("count",  bus.ballots_cast,   e_cnt);
            check("tmo",    bus.ballot_timeout, e_tmo);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change at negedge or 1 unit after posedge)
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue();
        bus.raw_ballot_issue = 1'b1; cyc(8);
        bus.raw_ballot_issue = 1'b0; cyc(10);
    endtask

    task automatic press_count(input logic [3:0] sw, input int hold, output int ns, output int ni);
        ns = 0; ni = 0;
        bus.raw_switch = sw; cyc(3);
        bus.raw_button = 1'b1;
        for (int i = 0; i < hold + 20; i++) begin
            @(posedge clk); #1;
            ns += int'(bus.vote_strobe);
            ni += int'(bus.invalid_sel);
            if (i == hold - 1) bus.raw_button = 1'b0;
        end
        @(negedge clk);
    endtask

    int ns, ni, lat, beeps, rc, saw;
    logic [3:0] party;

    initial begin
        reset = 1'b1;
        bus.voting_en = 1'b1; bus.raw_ballot_issue = 1'b0;
        bus.raw_button = 1'b0; bus.raw_switch = '0;
        model_reset();
        cyc(2);
        check("rst_strobe", bus.vote_strobe, 0);
        check("rst_count",  bus.ballots_cast, 0);
        check("rst_party",  bus.vote_party, 0);
        reset = 1'b0;
        cyc(3);

        // Clean press: latency, party, count, beep length.
        issue();
        check("armed", bus.ballot_ready, 1);
        bus.raw_switch = PARTY3; cyc(3);
        bus.raw_button = 1'b1;
        lat = 0;
        for (int i = 1; i <= 14 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (bus.vote_strobe) lat = i;
        end
        check("latency", lat, 8);
        check("party1", bus.vote_party, 4'b0100);
        check("count1", bus.ballots_cast, 1);
        beeps = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.beep) beeps++;
            if (i == 2) bus.raw_button = 1'b0;
            @(posedge clk); #1;
        end
        check("beep_len", beeps, LOCK);
        check("idle_after", bus.ballot_ready, 0);
        @(negedge clk);

        // Bouncing press then stable: exactly one strobe.
        issue();
        bus.raw_switch = PARTY2; cyc(3);
        for (int i = 0; i < 6; i++) begin
            bus.raw_button = (i % 2 == 0); cyc(1);
        end
        bus.raw_button = 1'b1;
        ns = 0;
        for (int i = 0; i < 25; i++) begin @(posedge clk); #1; ns += int'(bus.vote_strobe); end
        @(negedge clk); bus.raw_button = 1'b0; cyc(12);
        check("bounce_one", ns, 1);
        check("count2", bus.ballots_cast, 2);

        // Short glitch, invalid selections, then a valid one.
        issue();
        press_count(PARTY1, 3, ns, ni);
        check("glitch_none", ns + ni, 0);
        check("glitch_armed", bus.ballot_ready, 1);
        press_count(4'b0110, 10, ns, ni);
        check("multi_inv", ni, 1);
        check("multi_nostrobe", ns, 0);
        check("multi_armed", bus.ballot_ready, 1);
        press_count(4'b0000, 6, ns, ni);
        check("zero_inv", ni, 1);
        press_count(PARTY1, 10, ns, ni);
        check("valid_strobe", ns, 1);
        check("party_p1", bus.vote_party, 4'b0001);
        check("count3", bus.ballots_cast, 3);

        // Re-press landing in LOCKOUT, then a press with no ballot issued.
        issue();
        bus.raw_switch = PARTY4; cyc(3);
        bus.raw_button = 1'b1; ns = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            ns += int'(bus.vote_strobe);
            if (i == 4)  bus.raw_button = 1'b0;
            if (i == 8)  bus.raw_button = 1'b1;
            if (i == 20) bus.raw_button = 1'b0;
        end
        @(negedge clk);
        check("lockout_one", ns, 1);
        check("count4", bus.ballots_cast, 4);
        press_count(PARTY2, 10, ns, ni);
        check("no_issue_none", ns, 0);
        check("count4b", bus.ballots_cast, 4);

        // voting_en low while armed, and issue while voting closed.
        issue();
        bus.voting_en = 1'b0; cyc(1);
        check("en_low_idle", bus.ballot_ready, 0);
        bus.voting_en = 1'b1;
        press_count(PARTY2, 6, ns, ni);
        check("en_low_nostrobe", ns, 0);
        check("count4c", bus.ballots_cast, 4);
        bus.voting_en = 1'b0; issue();
        check("closed_no_arm", bus.ballot_ready, 0);
        bus.voting_en = 1'b1; cyc(2);

        // Armed ballot with no press.
        bus.raw_ballot_issue = 1'b1; rc = 0; saw = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (i == 8) bus.raw_ballot_issue = 1'b0;
            if (bus.ballot_ready) rc++;
            if (bus.ballot_timeout) begin
                saw++;
                check("tmo_ready_low", bus.ballot_ready, 0);
            end
        end
        @(negedge clk);
`ifdef BALLOT_TIMEOUT_EN
        check("tmo_ready_cycles", rc, TMO);
        check("tmo_pulse", saw, 1);
`else
        check("notmo_ready_cycles", rc, 53);
        check("notmo_pulse", saw, 0);
        bus.voting_en = 1'b0; cyc(2); bus.voting_en = 1'b1;
        check("notmo_close", bus.ballot_ready, 0);
`endif

        // Saturation over 130 more ballots.
        party = PARTY1;
        for (int k = 0; k < 130; k++) begin
            issue();
            party = 4'b0001 << $urandom_range(0, 3);
            press_count(party, 6, ns, ni);
            check("sat_strobe", ns, 1);
        end
        check("sat_count", bus.ballots_cast, 127);
        check("sat_party", bus.vote_party, party);

        // Asynchronous reset in the middle of LOCKOUT.
        issue();
        bus.raw_switch = PARTY3; cyc(3);
        bus.raw_button = 1'b1;
        cyc(11);
        check("pre_rst_beep", bus.beep, 1);
        #2; reset = 1'b1; model_reset(); #1;
        check("arst_strobe", bus.vote_strobe, 0);
        check("arst_party",  bus.vote_party, 0);
        check("arst_ready",  bus.ballot_ready, 0);
        check("arst_inv",    bus.invalid_sel, 0);
        check("arst_beep",   bus.beep, 0);
        check("arst_count",  bus.ballots_cast, 0);
        check("arst_tmo",    bus.ballot_timeout, 0);
        cyc(2); reset = 1'b0; bus.raw_button = 1'b0; cyc(12);
        issue();
        press_count(PARTY4, 8, ns, ni);
        check("post_rst_vote", bus.ballots_cast, 1);

        // Randomized phase with occasional asynchronous resets.
        for (int k = 0; k < 300; k++) begin
            bus.voting_en        = ($urandom_range(0, 9) != 0);
            bus.raw_ballot_issue = $urandom_range(0, 1);
            bus.raw_button       = $urandom_range(0, 1);
            bus.raw_switch       = ($urandom_range(0, 3) != 0) ? (4'b0001 << $urandom_range(0, 3))
                                                               : 4'($urandom_range(0, 15));
            cyc($urandom_range(1, 12));
            if ($urandom_range(0, 39) == 0) begin
                #2; reset = 1'b1; model_reset(); #1;
                check("rand_rst_count", bus.ballots_cast, 0);
                cyc(2); reset = 1'b0;
            end
        end
        cyc(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
